// File: rtl/nios2_mul_seq_pkg.sv
// Shared types and constants for the Nios II multiply sequencer.
package nios2_mul_seq_pkg;

  localparam int DATA_W = 32;
  localparam int HALF_W = 16;

  typedef enum logic [1:0] {
    OP_MUL    = 2'd0,
    OP_MULXUU = 2'd1,
    OP_MULXSS = 2'd2,
    OP_MULXSU = 2'd3
  } mul_op_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISS0  = 3'd1,
    ST_WAIT0 = 3'd2,
    ST_ISS1  = 3'd3,
    ST_WAIT1 = 3'd4,
    ST_FIX   = 3'd5,
    ST_DONE  = 3'd6
  } seq_state_e;

endpackage

// File: rtl/nios2_mul_seq_combine.sv
// Combinational result assembly from the 16x16 cell partial products.
// lo32 is the MUL result. hi32 is the signed/unsigned high word, and it is
// built only when NIOS2_MUL_SEQ_MULX_EN is defined (otherwise it is tied to 0).
module nios2_mul_seq_combine
  import nios2_mul_seq_pkg::*;
(
  input  logic [DATA_W-1:0] p1,
  input  logic [DATA_W-1:0] p2,
  input  logic [DATA_W-1:0] p3,
  input  logic [DATA_W-1:0] hh,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  mul_op_e           op,
  output logic [DATA_W-1:0] lo32,
  output logic [DATA_W-1:0] hi32
);

  logic [HALF_W-1:0] cross_lo_s;

  // Low word: the cross terms only reach the upper half, so their sum wraps at 16 bits.
  always_comb begin
    cross_lo_s = p2[HALF_W-1:0] + p3[HALF_W-1:0];
    lo32       = p1 + {cross_lo_s, 16'h0000};
  end

`ifdef NIOS2_MUL_SEQ_MULX_EN
  logic [DATA_W-1:0] mid_s;
  logic [DATA_W-1:0] hu_s;

  // High word: unsigned 64-bit upper half, then the two's-complement sign corrections.
  always_comb begin
    mid_s = {16'h0000, p1[DATA_W-1:HALF_W]} + {16'h0000, p2[HALF_W-1:0]}
          + {16'h0000, p3[HALF_W-1:0]};
    hu_s  = hh + {16'h0000, p2[DATA_W-1:HALF_W]} + {16'h0000, p3[DATA_W-1:HALF_W]}
          + {16'h0000, mid_s[DATA_W-1:HALF_W]};
    case (op)
      OP_MULXUU: hi32 = hu_s;
      OP_MULXSS: hi32 = hu_s - (a[DATA_W-1] ? b : 32'h0000_0000)
                             - (b[DATA_W-1] ? a : 32'h0000_0000);
      OP_MULXSU: hi32 = hu_s - (a[DATA_W-1] ? b : 32'h0000_0000);
      default:   hi32 = 32'h0000_0000;
    endcase
  end
`else
  logic unused_hi_s;

  // The high word is not built in this configuration.
  always_comb begin
    hi32        = 32'h0000_0000;
    unused_hi_s = ^{p2[DATA_W-1:HALF_W], p3[DATA_W-1:HALF_W], hh, a, b, op};
  end
`endif

endmodule

// File: rtl/nios2_mul_sequencer.sv
// Initiator-side controller for the three-partial-product 16x16 multiplier cell.
// Optional feature macro: NIOS2_MUL_SEQ_MULX_EN enables MULXUU/MULXSS/MULXSU;
// without it those ops complete with res_illegal=1 and res_data=0.
module nios2_mul_sequencer #(
  parameter int DATA_W = 32,
  parameter int OPC_W  = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [OPC_W-1:0]  cmd_op,
  input  logic [DATA_W-1:0] cmd_a,
  input  logic [DATA_W-1:0] cmd_b,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_data,
  output logic              res_illegal,
  output logic [DATA_W-1:0] mul_src1,
  output logic [DATA_W-1:0] mul_src2,
  output logic              mul_en,
  input  logic [DATA_W-1:0] mul_p1,
  input  logic [DATA_W-1:0] mul_p2,
  input  logic [DATA_W-1:0] mul_p3
);
  import nios2_mul_seq_pkg::*;

  seq_state_e        state_r;
  mul_op_e           op_r;
  logic [DATA_W-1:0] a_r, b_r;
  logic [DATA_W-1:0] p1_r, p2_r, p3_r;
  logic [DATA_W-1:0] cp1_s, cp2_s, cp3_s, hh_s;
  logic [DATA_W-1:0] lo32_s, hi32_s;

`ifdef NIOS2_MUL_SEQ_MULX_EN
  logic [DATA_W-1:0] hh_r;
  assign hh_s = hh_r;
`else
  logic unused_hi_s;
  assign hh_s        = 32'h0000_0000;
  assign unused_hi_s = ^hi32_s;
`endif

  // In WAIT0 the partials are still on the cell outputs; afterwards use the captured copies.
  always_comb begin
    if (state_r == ST_WAIT0) begin
      cp1_s = mul_p1;
      cp2_s = mul_p2;
      cp3_s = mul_p3;
    end else begin
      cp1_s = p1_r;
      cp2_s = p2_r;
      cp3_s = p3_r;
    end
  end

  nios2_mul_seq_combine u_combine (
    .p1   (cp1_s),
    .p2   (cp2_s),
    .p3   (cp3_s),
    .hh   (hh_s),
    .a    (a_r),
    .b    (b_r),
    .op   (op_r),
    .lo32 (lo32_s),
    .hi32 (hi32_s)
  );

  // Sequencer FSM; all handshake and cell-facing outputs are registered here.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r     <= ST_IDLE;
      op_r        <= OP_MUL;
      a_r         <= 32'h0000_0000;
      b_r         <= 32'h0000_0000;
      p1_r        <= 32'h0000_0000;
      p2_r        <= 32'h0000_0000;
      p3_r        <= 32'h0000_0000;
`ifdef NIOS2_MUL_SEQ_MULX_EN
      hh_r        <= 32'h0000_0000;
`endif
      cmd_ready   <= 1'b1;
      res_valid   <= 1'b0;
      res_data    <= 32'h0000_0000;
      res_illegal <= 1'b0;
      mul_en      <= 1'b0;
      mul_src1    <= 32'h0000_0000;
      mul_src2    <= 32'h0000_0000;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (cmd_valid) begin
            op_r      <= mul_op_e'(cmd_op);
            a_r       <= cmd_a;
            b_r       <= cmd_b;
            mul_src1  <= cmd_a;
            mul_src2  <= cmd_b;
            mul_en    <= 1'b1;
            cmd_ready <= 1'b0;
            state_r   <= ST_ISS0;
          end
        end
        ST_ISS0: begin
          mul_en  <= 1'b0;
          state_r <= ST_WAIT0;
        end
        ST_WAIT0: begin
          p1_r <= mul_p1;
          p2_r <= mul_p2;
          p3_r <= mul_p3;
          if (op_r == OP_MUL) begin
            res_data    <= lo32_s;
            res_illegal <= 1'b0;
            res_valid   <= 1'b1;
            state_r     <= ST_DONE;
          end else begin
`ifdef NIOS2_MUL_SEQ_MULX_EN
            mul_src1 <= {16'h0000, a_r[DATA_W-1:16]};
            mul_src2 <= {16'h0000, b_r[DATA_W-1:16]};
            mul_en   <= 1'b1;
            state_r  <= ST_ISS1;
`else
            res_data    <= 32'h0000_0000;
            res_illegal <= 1'b1;
            res_valid   <= 1'b1;
            state_r     <= ST_DONE;
`endif
          end
        end
`ifdef NIOS2_MUL_SEQ_MULX_EN
        ST_ISS1: begin
          mul_en  <= 1'b0;
          state_r <= ST_WAIT1;
        end
        ST_WAIT1: begin
          hh_r    <= mul_p1;
          state_r <= ST_FIX;
        end
        ST_FIX: begin
          res_data    <= hi32_s;
          res_illegal <= 1'b0;
          res_valid   <= 1'b1;
          state_r     <= ST_DONE;
        end
`endif
        ST_DONE: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state_r   <= ST_IDLE;
          end
        end
        default: begin
          mul_en    <= 1'b0;
          res_valid <= 1'b0;
          cmd_ready <= 1'b1;
          state_r   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nios2_mul_sequencer.sv
// Self-checking bench for nios2_mul_sequencer with a behavioural 16x16 cell model.
module tb_nios2_mul_sequencer;

`ifdef NIOS2_MUL_SEQ_MULX_EN
  localparam bit MULX_EN = 1'b1;
`else
  localparam bit MULX_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'd0;
  logic [31:0] cmd_a = 32'h0, cmd_b = 32'h0;
  logic        res_valid;
  logic        res_ready = 1'b1;
  logic [31:0] res_data;
  logic        res_illegal;
  logic [31:0] mul_src1, mul_src2;
  logic        mul_en;
  logic [31:0] mul_p1 = 32'h0, mul_p2 = 32'h0, mul_p3 = 32'h0;

  int checks = 0;
  int failures = 0;
  logic [32:0] sb_q[$];

  always #5 clk = ~clk;

  nios2_mul_sequencer #(.DATA_W(32), .OPC_W(2)) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_illegal(res_illegal),
    .mul_src1(mul_src1), .mul_src2(mul_src2), .mul_en(mul_en),
    .mul_p1(mul_p1), .mul_p2(mul_p2), .mul_p3(mul_p3)
  );

  // Multiplier cell: registers the three partials while enabled, holds otherwise.
  always @(posedge clk) begin
    if (mul_en) begin
      mul_p1 <= {16'h0, mul_src1[15:0]}  * {16'h0, mul_src2[15:0]};
      mul_p2 <= {16'h0, mul_src1[15:0]}  * {16'h0, mul_src2[31:16]};
      mul_p3 <= {16'h0, mul_src1[31:16]} * {16'h0, mul_src2[15:0]};
    end
  end

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference result {illegal, data} from full-width 64-bit arithmetic.
  function automatic logic [32:0] model(input logic [1:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    logic [63:0] ua, ub, sa, sb, p;
    ua = {32'h0, a};
    ub = {32'h0, b};
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    p  = ua * ub;
    if (op == 2'd0) return {1'b0, p[31:0]};
    if (!MULX_EN) return {1'b1, 32'h0};
    case (op)
      2'd1:    p = ua * ub;
      2'd2:    p = sa * sb;
      default: p = sa * ub;
    endcase
    return {1'b0, p[63:32]};
  endfunction

  function automatic int exp_lat(input logic [1:0] op);
    return (MULX_EN && op != 2'd0) ? 6 : 3;
  endfunction

  // Scoreboard: each result consumed by a handshake is compared with the oldest expectation.
  always @(negedge clk) begin
    if (reset_n && res_valid && res_ready) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_result: got %h expected none", res_data);
      end else begin
        logic [32:0] e;
        e = sb_q.pop_front();
        chk("res_data", res_data, e[31:0]);
        chk("res_illegal", {31'h0, res_illegal}, {31'h0, e[32]});
      end
    end
  end

  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [32:0] exp, input bit push);
    bit ok;
    @(posedge clk);
    #1;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_a     = a;
    cmd_b     = b;
    ok        = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (cmd_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    if (push) sb_q.push_back(exp);
    #1;
    cmd_valid = 1'b0;
  endtask

  // Counts edges from acceptance until res_valid is sampled high.
  task automatic wait_result(input int exp, input int lat0);
    int  lat;
    bit  got;
    lat = lat0;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (res_valid) begin
        got = 1'b1;
        break;
      end
      @(posedge clk);
      lat++;
    end
    if (!got) chk("result_timeout", 32'd0, 32'd1);
    else chk("latency", lat, exp);
  endtask

  initial begin
    logic [1:0]  op;
    logic [31:0] a, b;
    logic [32:0] e;

    tbl[0] = '{2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001};
    tbl[1] = '{2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
    tbl[2] = '{2'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000};
    tbl[3] = '{2'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    tbl[4] = '{2'd1, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001};
    tbl[5] = '{2'd0, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000};
    tbl[6] = '{2'd2, 32'h8000_0000, 32'h0000_0002, 32'hFFFF_FFFF};
    tbl[7] = '{2'd0, 32'h0000_0003, 32'h0000_0005, 32'h0000_000F};

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_cmd_ready", {31'h0, cmd_ready}, 32'd1);
    chk("rst_res_valid", {31'h0, res_valid}, 32'd0);
    chk("rst_res_data", res_data, 32'd0);
    chk("rst_res_illegal", {31'h0, res_illegal}, 32'd0);
    chk("rst_mul_en", {31'h0, mul_en}, 32'd0);
    chk("rst_mul_src1", mul_src1, 32'd0);
    chk("rst_mul_src2", mul_src2, 32'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // Directed vectors
    for (int i = 0; i < 8; i++) begin
      e = (tbl[i].op == 2'd0 || MULX_EN) ? {1'b0, tbl[i].exp} : {1'b1, 32'h0};
      issue(tbl[i].op, tbl[i].a, tbl[i].b, e, 1'b1);
      wait_result(exp_lat(tbl[i].op), 1);
    end

    // Random vectors against the 64-bit model
    for (int i = 0; i < 8; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = $urandom;
      b  = $urandom;
      issue(op, a, b, model(op, a, b), 1'b1);
      wait_result(exp_lat(op), 1);
    end

    // Backpressure in DONE
    @(posedge clk);
    #1;
    res_ready = 1'b0;
    issue(2'd0, 32'd7, 32'd9, {1'b0, 32'd63}, 1'b1);
    wait_result(3, 1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b1;
    cmd_op    = 2'd0;
    cmd_a     = 32'd6;
    cmd_b     = 32'd4;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_res_valid", {31'h0, res_valid}, 32'd1);
      chk("bp_res_data", res_data, 32'd63);
      chk("bp_cmd_ready", {31'h0, cmd_ready}, 32'd0);
      chk("bp_mul_en", {31'h0, mul_en}, 32'd0);
    end
    @(posedge clk);
    #1;
    res_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("bp_free_cmd_ready", {31'h0, cmd_ready}, 32'd1);
    @(posedge clk);
    sb_q.push_back({1'b0, 32'd24});
    #1;
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("bp_next_accepted", {31'h0, mul_en}, 32'd1);
    wait_result(3, 2);

    // Reset mid-operation (WAIT1 when the extended ops are built)
    @(posedge clk);
    #1;
    res_ready = 1'b0;
    issue(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33'h0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(negedge clk);
    chk("mid_rst_cmd_ready", {31'h0, cmd_ready}, 32'd1);
    chk("mid_rst_res_valid", {31'h0, res_valid}, 32'd0);
    chk("mid_rst_mul_en", {31'h0, mul_en}, 32'd0);
    res_ready = 1'b1;
    issue(2'd0, 32'd3, 32'd5, {1'b0, 32'd15}, 1'b1);
    wait_result(3, 1);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("scoreboard_empty", sb_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
